alu_ctrl_mdu: RTL and testbench

- Next-generation ALU control unit for the RV32 core: decodes ALUOp/Funct7/Funct3 into the ALU Operation code and adds an iterative M-extension multiply/divide sequencer.
- Sits in EX beside the ALU.
- Base ops: Operation is combinational, as before.
- M ops (R-type, Funct7=0000001): run in a multi-cycle datapath that stalls the pipeline via busy.
- Fixes I-type/sub aliasing with an explicit is_rtype qualifier and adds unsigned compare/branch codes.

---
 rtl/alu_ctrl_pkg.sv | 44 ++++
 rtl/alu_ctrl_mdu_if.sv | 31 +++
 rtl/md_iter_unit.sv | 103 ++++++++++
 rtl/alu_ctrl_mdu.sv | 128 ++++++++++++
 tb/tb_alu_ctrl_mdu.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and codes for the ALU control / MDU block
package alu_ctrl_pkg;

  // ALUOp as produced by the main decoder
  typedef enum logic [1:0] {
    LSU    = 2'b00,
    BRANCH = 2'b01,
    ARITH  = 2'b10,
    JUMP   = 2'b11
  } alu_op_e;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // ALU operation codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BGE  = 4'b1010;
  localparam logic [3:0] OP_BGEU = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_JUMP = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1110;
  // Branch compares reuse the set-less-than codes
  localparam logic [3:0] OP_BLT  = OP_SLT;
  localparam logic [3:0] OP_BLTU = OP_SLTU;

  // funct7 values of interest
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// rtl/alu_ctrl_mdu_if.sv - EX-stage bus between pipeline and ALU control / MDU
// master: pipeline side (drives decode fields, operands, in_valid, flush)
// slave : alu_ctrl_mdu (drives operation, md_sel, busy, md_result, md_valid)
interface alu_ctrl_mdu_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic [1:0]      alu_op;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            is_rtype;
  logic            in_valid;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [OP_W-1:0] operation;
  logic            md_sel;
  logic            busy;
  logic [XLEN-1:0] md_result;
  logic            md_valid;

  modport master (
    output alu_op, funct7, funct3, is_rtype, in_valid, flush, op_a, op_b,
    input  operation, md_sel, busy, md_result, md_valid
  );

  modport slave (
    input  alu_op, funct7, funct3, is_rtype, in_valid, flush, op_a, op_b,
    output operation, md_sel, busy, md_result, md_valid
  );
endinterface

// File: rtl/md_iter_unit.sv
// rtl/md_iter_unit.sv - iterative shift-add multiplier / restoring divider datapath
// Ports: clk, rst_n (async active-low); load latches operands/funct3 and clears
// the counter; step performs one iteration; last flags the final iteration;
// result is the sign-corrected M-op result selected by the latched funct3.
module md_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic              a_neg, b_neg, div_zero;
  // mul: acc_lo holds the multiplier, opnd the multiplicand
  // div: acc_lo holds dividend/quotient bits, acc_hi the partial remainder, opnd the divisor
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd;

  logic              a_signed, b_signed, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum, shl_rem, sub_diff;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quot, rem;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in = a_signed & op_a[XLEN-1];
    b_neg_in = b_signed & op_b[XLEN-1];
    // -(-2^(XLEN-1)) wraps to 2^(XLEN-1), which is the correct unsigned magnitude
    mag_a    = a_neg_in ? -op_a : op_a;
    mag_b    = b_neg_in ? -op_b : op_b;
  end

  always_comb begin
    add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shl_rem  = {acc_hi, acc_lo[XLEN-1]};
    // MSB set means the trial subtraction borrowed
    sub_diff = shl_rem - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      f3       <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
    end else if (load) begin
      cnt      <= '0;
      f3       <= funct3;
      a_neg    <= a_neg_in;
      b_neg    <= b_neg_in;
      div_zero <= funct3[2] && (op_b == '0);
      acc_hi   <= '0;
      acc_lo   <= funct3[2] ? mag_a : mag_b;
      opnd     <= funct3[2] ? mag_b : mag_a;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (f3[2]) begin
        if (!sub_diff[XLEN]) begin
          acc_hi <= sub_diff[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
        end else begin
          acc_hi <= shl_rem[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {acc_hi, acc_lo} <= {add_sum, acc_lo[XLEN-1:1]};
      end
    end
  end

  assign last = (cnt == CW'(XLEN - 1));

  always_comb begin
    prod_neg = -{acc_hi, acc_lo};
    // Divide by zero leaves the magnitude quotient all-ones; force it so the
    // sign fixup cannot turn it into +1.
    quot     = div_zero ? '1 : ((a_neg ^ b_neg) ? -acc_lo : acc_lo);
    // Remainder takes the dividend's sign, which also yields op_a on divide by zero
    rem      = a_neg ? -acc_hi : acc_hi;
    case (f3)
      3'b000:         result = acc_lo;
      3'b001, 3'b010: result = (a_neg ^ b_neg) ? prod_neg[2*XLEN-1:XLEN] : acc_hi;
      3'b011:         result = acc_hi;
      3'b100, 3'b101: result = quot;
      default:        result = rem;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - ALU control decode plus multi-cycle M-extension sequencer
// Ports: clk, rst_n (async active-low), bus (alu_ctrl_mdu_if.slave):
//   decode inputs alu_op/funct7/funct3/is_rtype -> operation, md_sel (combinational)
//   in_valid/flush/op_a/op_b -> busy (stall), md_result/md_valid (one-cycle pulse)
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int OP_W   = 4,
  parameter bit MDU_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_mdu_if.slave bus
);
  logic       is_m, f7_base, imm_ok;
  logic [3:0] op_code;

  assign f7_base = (bus.funct7 == F7_BASE);
  // I-type arithmetic carries immediate bits in funct7, so only R-type needs F7_BASE
  assign imm_ok  = !bus.is_rtype || f7_base;
  assign is_m    = (bus.alu_op == ARITH) && bus.is_rtype && (bus.funct7 == F7_MULDIV);

  always_comb begin
    op_code = OP_AND;
    case (alu_op_e'(bus.alu_op))
      LSU:  op_code = OP_ADD;
      JUMP: op_code = OP_JUMP;
      BRANCH: begin
        case (bus.funct3)
          3'b000:  op_code = OP_BEQ;
          3'b001:  op_code = OP_BNE;
          3'b100:  op_code = OP_BLT;
          3'b101:  op_code = OP_BGE;
          3'b110:  op_code = OP_BLTU;
          3'b111:  op_code = OP_BGEU;
          default: op_code = OP_AND;
        endcase
      end
      ARITH: begin
        if (is_m) begin
          op_code = OP_ADD;
        end else begin
          case (bus.funct3)
            3'b000: if (imm_ok) op_code = OP_ADD;
                    else if (bus.funct7 == F7_ALT) op_code = OP_SUB;
            3'b001: if (f7_base) op_code = OP_SLL;
            3'b010: if (imm_ok) op_code = OP_SLT;
            3'b011: if (imm_ok) op_code = OP_SLTU;
            3'b100: if (imm_ok) op_code = OP_XOR;
            3'b101: if (f7_base) op_code = OP_SRL;
                    else if (bus.funct7 == F7_ALT) op_code = OP_SRA;
            3'b110: if (imm_ok) op_code = OP_OR;
            default: op_code = OP_AND;
          endcase
        end
      end
    endcase
  end

  assign bus.operation = OP_W'(op_code);

  if (MDU_EN) begin : g_mdu
    md_state_e       state, state_nxt;
    logic            prev_done, start, busy, md_valid, last;
    logic [XLEN-1:0] result;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        prev_done <= 1'b0;
      end else begin
        state     <= state_nxt;
        prev_done <= (state == DONE);
      end
    end

    always_comb begin
      state_nxt = state;
      start     = 1'b0;
      busy      = 1'b0;
      md_valid  = 1'b0;
      case (state)
        IDLE: begin
          // The instruction is still presented in the cycle after DONE; prev_done
          // stops it being accepted a second time. rst_n keeps busy low during reset.
          start = rst_n && bus.in_valid && is_m && !bus.flush && !prev_done;
          if (start) begin
            busy      = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          busy = 1'b1;
          if (bus.flush)  state_nxt = IDLE;
          else if (last)  state_nxt = DONE;
        end
        DONE: begin
          md_valid  = !bus.flush;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    md_iter_unit #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (start),
      .step   (state == RUN),
      .funct3 (bus.funct3),
      .op_a   (bus.op_a),
      .op_b   (bus.op_b),
      .last   (last),
      .result (result)
    );

    assign bus.md_sel    = is_m;
    assign bus.busy      = busy;
    assign bus.md_valid  = md_valid;
    assign bus.md_result = (state == DONE) ? result : '0;
  end else begin : g_no_mdu
    assign bus.md_sel    = 1'b0;
    assign bus.busy      = 1'b0;
    assign bus.md_valid  = 1'b0;
    assign bus.md_result = '0;
  end
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb/tb_alu_ctrl_mdu.sv - self-checking scoreboard bench for alu_ctrl_mdu
module tb_alu_ctrl_mdu;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_issued = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  alu_ctrl_mdu_if #(.XLEN(32), .OP_W(4)) bus ();

  alu_ctrl_mdu #(.XLEN(32), .OP_W(4), .MDU_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", nm, got, exp);
  endtask

  // Scoreboard monitor: every md_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.md_valid) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_md_valid got %h expected no pulse", bus.md_result);
      end else begin
        automatic logic [31:0] e  = exp_q.pop_front();
        automatic string       nm = name_q.pop_front();
        if (bus.md_result === e) n_pass++;
        else $display("FAIL %s got %h expected %h", nm, bus.md_result, e);
      end
    end
  end

  task automatic decode(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic rt, input logic [3:0] exp, input string nm);
    bus.alu_op = op; bus.funct3 = f3; bus.funct7 = f7; bus.is_rtype = rt;
    #1;
    chk(nm, 32'(bus.operation), 32'(exp));
  endtask

  // Issue one M op, hold it through DONE and the following cycle, then release it.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm, output int lat);
    int cyc;
    @(posedge clk); #1;
    bus.alu_op = 2'b10; bus.funct7 = 7'b0000001; bus.funct3 = f3; bus.is_rtype = 1'b1;
    bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
    exp_q.push_back(exp); name_q.push_back(nm);
    n_issued++;
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.md_valid) lat = cyc;
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL %s_timeout got no md_valid expected pulse", nm);
      void'(exp_q.pop_back()); void'(name_q.pop_back());
      n_issued--;
    end
    @(negedge clk);
    chk({nm, "_no_reaccept_busy"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    bus.alu_op = 2'b00; bus.funct7 = '0; bus.funct3 = '0; bus.is_rtype = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.op_a = '0; bus.op_b = '0;
    #12;
    chk("reset_busy",      32'(bus.busy),     32'd0);
    chk("reset_md_valid",  32'(bus.md_valid), 32'd0);
    chk("reset_md_result", bus.md_result,     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Decode sweep
    decode(2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0110, "dec_sub");
    decode(2'b10, 3'b000, 7'b0100000, 1'b0, 4'b0010, "dec_addi_imm");
    decode(2'b01, 3'b111, 7'b0000000, 1'b0, 4'b1011, "dec_bgeu");
    decode(2'b11, 3'b000, 7'b0000000, 1'b0, 4'b1101, "dec_jump");
    decode(2'b00, 3'b010, 7'b0000000, 1'b0, 4'b0010, "dec_lw");
    decode(2'b01, 3'b100, 7'b0000000, 1'b0, 4'b1100, "dec_blt");
    decode(2'b10, 3'b101, 7'b0100000, 1'b1, 4'b0111, "dec_sra");
    decode(2'b10, 3'b011, 7'b1111111, 1'b0, 4'b1110, "dec_sltiu");
    decode(2'b10, 3'b001, 7'b0100000, 1'b1, 4'b0000, "dec_undef");
    decode(2'b10, 3'b110, 7'b0000001, 1'b1, 4'b0010, "dec_mop_add");
    chk("md_sel_mop", 32'(bus.md_sel), 32'd1);
    decode(2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0110, "dec_sub_again");
    chk("md_sel_sub", 32'(bus.md_sel), 32'd0);

    // Multiply family
    run_md(3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul", lat);
    chk("mul_latency", 32'(lat), 32'd34);
    run_md(3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "mulhu", lat);
    run_md(3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulh", lat);
    run_md(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", lat);

    // Divide family and corner cases
    run_md(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", lat);
    run_md(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", lat);
    run_md(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu_by0", lat);
    chk("divu_by0_latency", 32'(lat), 32'd34);
    run_md(3'b110, 32'd7, 32'd0, 32'd7, "rem_by0", lat);
    run_md(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div_neg_by0", lat);
    run_md(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_neg_by0", lat);
    run_md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", lat);
    run_md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf", lat);
    run_md(3'b111, 32'd100, 32'd7, 32'd2, "remu", lat);
    run_md(3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "divu", lat);

    // Flush during RUN
    @(posedge clk); #1;
    bus.alu_op = 2'b10; bus.funct7 = 7'b0000001; bus.funct3 = 3'b000; bus.is_rtype = 1'b1;
    bus.op_a = 32'd9; bus.op_b = 32'd9; bus.in_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_next_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    run_md(3'b000, 32'd3, 32'd5, 32'd15, "mul_after_flush", lat);

    // Asynchronous reset mid-RUN with the instruction still presented
    @(posedge clk); #1;
    bus.funct3 = 3'b000; bus.op_a = 32'd6; bus.op_b = 32'd7; bus.in_valid = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy",      32'(bus.busy),     32'd0);
    chk("async_rst_md_valid",  32'(bus.md_valid), 32'd0);
    chk("async_rst_md_result", bus.md_result,     32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    run_md(3'b100, 32'd100, 32'd10, 32'd10, "div_after_rst", lat);

    // Back-to-back issue, each held through DONE
    run_md(3'b000, 32'd12, 32'd12, 32'd144, "b2b_mul", lat);
    run_md(3'b101, 32'd144, 32'd12, 32'd12, "b2b_divu", lat);
    repeat (5) @(negedge clk);

    chk("md_valid_count", 32'(n_valid), 32'(n_issued));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
